// File: rtl/seq_restoring_divider_pkg.sv
// rtl/seq_restoring_divider_pkg.sv - shared types, default widths and counter sizing for the divider
package div_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } div_state_t;

  localparam int DIV_DW = 8;
  localparam int DIV_VW = 4;

  // Iteration counter must be able to hold the value DW.
  function automatic int div_cnt_w(input int dw);
    return $clog2(dw + 1);
  endfunction

endpackage

// File: rtl/seq_restoring_divider_if.sv
// rtl/seq_restoring_divider_if.sv - start/busy/done operand and result bundle for the divider
interface seq_restoring_divider_if
  import div_pkg::*;
#(
  parameter int DW = DIV_DW,
  parameter int VW = DIV_VW
);

  logic          start;
  logic [DW-1:0] dividend;
  logic [VW-1:0] divisor;
  logic          busy;
  logic          done;
  logic [DW-1:0] quotient;
  logic [VW-1:0] remainder;
  logic          div_by_zero;

  modport master (
    output start, dividend, divisor,
    input  busy, done, quotient, remainder, div_by_zero
  );

  modport slave (
    input  start, dividend, divisor,
    output busy, done, quotient, remainder, div_by_zero
  );

endinterface

// File: rtl/seq_restoring_divider_step.sv
// rtl/seq_restoring_divider_step.sv - one combinational restoring step: shift in a bit, trial-subtract
module div_step
  import div_pkg::*;
#(
  parameter int VW = DIV_VW
) (
  input  logic [VW:0]   rem_in,
  input  logic          bit_in,
  input  logic [VW-1:0] divisor,
  output logic [VW:0]   rem_out,
  output logic          q_bit
);

  logic [VW+1:0] shifted;
  logic [VW+1:0] dvsr_ext;

  // One bit of headroom keeps the compare exact even if rem_in's MSB is set.
  assign shifted  = {rem_in, bit_in};
  assign dvsr_ext = {2'b00, divisor};
  assign q_bit    = (shifted >= dvsr_ext);
  assign rem_out  = (VW+1)'(q_bit ? (shifted - dvsr_ext) : shifted);

endmodule

// File: rtl/seq_restoring_divider.sv
// rtl/seq_restoring_divider.sv - sequential restoring divider, one quotient bit per clock
// Optional DIV_ZERO_FAST_EN: a zero divisor finishes one edge after accept without asserting busy.
module seq_restoring_divider
  import div_pkg::*;
#(
  parameter int DW = DIV_DW,
  parameter int VW = DIV_VW
) (
  input  logic                    clk,
  input  logic                    rst_n,
  seq_restoring_divider_if.slave  bus
);

  localparam int CW = div_cnt_w(DW);
  localparam logic [CW-1:0] LAST_ITER = CW'(DW - 1);

  div_state_t    state_q, state_d;
  logic [DW-1:0] shreg_q, shreg_d;
  logic [VW:0]   rem_q, rem_d;
  logic [VW-1:0] dvsr_q, dvsr_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;
  logic [DW-1:0] quot_q, quot_d;
  logic [VW-1:0] remo_q, remo_d;
  logic          dbz_q, dbz_d;

  logic [VW:0]   step_rem;
  logic          step_q;
  logic [DW-1:0] shreg_next;
  logic          dvsr_zero;

  div_step #(.VW(VW)) u_step (
    .rem_in  (rem_q),
    .bit_in  (shreg_q[DW-1]),
    .divisor (dvsr_q),
    .rem_out (step_rem),
    .q_bit   (step_q)
  );

  // Dividend bits leave at the MSB while quotient bits enter at the LSB.
  assign shreg_next = {shreg_q[DW-2:0], step_q};
  assign dvsr_zero  = (dvsr_q == '0);

  always_comb begin
    state_d = state_q;
    shreg_d = shreg_q;
    rem_d   = rem_q;
    dvsr_d  = dvsr_q;
    cnt_d   = cnt_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    quot_d  = quot_q;
    remo_d  = remo_q;
    dbz_d   = dbz_q;
    case (state_q)
      IDLE, DONE: begin
        if (bus.start) begin
          state_d = RUN;
          shreg_d = bus.dividend;
          rem_d   = '0;
          dvsr_d  = bus.divisor;
          cnt_d   = '0;
`ifdef DIV_ZERO_FAST_EN
          busy_d  = (bus.divisor != '0);
`else
          busy_d  = 1'b1;
`endif
        end else begin
          state_d = IDLE;
          busy_d  = 1'b0;
        end
      end
      RUN: begin
        shreg_d = shreg_next;
        rem_d   = step_rem;
        cnt_d   = cnt_q + CW'(1);
`ifdef DIV_ZERO_FAST_EN
        if (dvsr_zero) begin
          state_d = DONE;
          busy_d  = 1'b0;
          done_d  = 1'b1;
          quot_d  = '1;
          remo_d  = '0;
          dbz_d   = 1'b1;
        end else
`endif
        if (cnt_q == LAST_ITER) begin
          state_d = DONE;
          busy_d  = 1'b0;
          done_d  = 1'b1;
          quot_d  = shreg_next;
          remo_d  = dvsr_zero ? '0 : step_rem[VW-1:0];
          dbz_d   = dvsr_zero;
        end
      end
      default: begin
        state_d = IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      shreg_q <= '0;
      rem_q   <= '0;
      dvsr_q  <= '0;
      cnt_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      quot_q  <= '0;
      remo_q  <= '0;
      dbz_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      shreg_q <= shreg_d;
      rem_q   <= rem_d;
      dvsr_q  <= dvsr_d;
      cnt_q   <= cnt_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      quot_q  <= quot_d;
      remo_q  <= remo_d;
      dbz_q   <= dbz_d;
    end
  end

  assign bus.busy        = busy_q;
  assign bus.done        = done_q;
  assign bus.quotient    = quot_q;
  assign bus.remainder   = remo_q;
  assign bus.div_by_zero = dbz_q;

endmodule

// File: tb/tb_seq_restoring_divider.sv
// tb/tb_seq_restoring_divider.sv - directed self-checking bench for seq_restoring_divider
module tb_seq_restoring_divider;

  logic clk;
  logic rst_n;
  int   total;
  int   bad;

  seq_restoring_divider_if #(.DW(8), .VW(4)) bus ();

  seq_restoring_divider #(.DW(8), .VW(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

`ifdef DIV_ZERO_FAST_EN
  localparam int ZERO_LAT  = 1;
  localparam int ZERO_BUSY = 0;
`else
  localparam int ZERO_LAT  = 8;
  localparam int ZERO_BUSY = 8;
`endif

  // Called at #1 after a rising edge with the DUT in IDLE or DONE.
  task automatic do_op(input logic [7:0] a, input logic [3:0] b,
                       output int lat, output int bcnt, output logic first_done);
    logic timed_out;
    bus.start    = 1'b1;
    bus.dividend = a;
    bus.divisor  = b;
    @(posedge clk); #1;
    bus.start    = 1'b0;
    bus.dividend = 8'($urandom);
    bus.divisor  = 4'($urandom);
    lat        = 0;
    bcnt       = int'(bus.busy);
    first_done = bus.done;
    timed_out  = 1'b1;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk); #1;
      lat++;
      if (bus.done) begin
        timed_out = 1'b0;
        break;
      end
      if (bus.busy) bcnt++;
    end
    total++;
    if (timed_out) begin
      bad++;
      $display("FAIL op_timeout a=%0d b=%0d: done not seen within 40 cycles", a, b);
    end
  endtask

  task automatic idle_cycle();
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    bus.start = 1'b0;
    bus.dividend = 8'd0;
    bus.divisor = 4'd0;
    repeat (3) @(posedge clk);
    #1;
    total += 5;
    if (bus.busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b want=0", bus.busy); end
    if (bus.done !== 1'b0) begin bad++; $display("FAIL reset_done got=%b want=0", bus.done); end
    if (bus.div_by_zero !== 1'b0) begin bad++; $display("FAIL reset_dbz got=%b want=0", bus.div_by_zero); end
    if (bus.quotient !== 8'd0) begin bad++; $display("FAIL reset_quot got=%0d want=0", bus.quotient); end
    if (bus.remainder !== 4'd0) begin bad++; $display("FAIL reset_rem got=%0d want=0", bus.remainder); end
    rst_n = 1'b1;
  endtask

  // Starts in the same cycle reset is released.
  task automatic test_basic();
    int lat, bcnt;
    logic fd;
    do_op(8'd200, 4'd7, lat, bcnt, fd);
    total += 5;
    if (bus.quotient !== 8'd28) begin bad++; $display("FAIL basic_quot got=%0d want=28", bus.quotient); end
    if (bus.remainder !== 4'd4) begin bad++; $display("FAIL basic_rem got=%0d want=4", bus.remainder); end
    if (bus.div_by_zero !== 1'b0) begin bad++; $display("FAIL basic_dbz got=%b want=0", bus.div_by_zero); end
    if (lat != 8) begin bad++; $display("FAIL basic_latency got=%0d want=8", lat); end
    if (bcnt != 8) begin bad++; $display("FAIL basic_busy_cycles got=%0d want=8", bcnt); end
    idle_cycle();
    total++;
    if (bus.done !== 1'b0) begin bad++; $display("FAIL basic_done_pulse got=%b want=0", bus.done); end
  endtask

  task automatic test_vectors();
    logic [7:0] va [3];
    logic [3:0] vb [3];
    logic [7:0] vq [3];
    logic [3:0] vr [3];
    int lat, bcnt;
    logic fd;
    va[0] = 8'd255; vb[0] = 4'd1;  vq[0] = 8'd255; vr[0] = 4'd0;
    va[1] = 8'd5;   vb[1] = 4'd9;  vq[1] = 8'd0;   vr[1] = 4'd5;
    va[2] = 8'd0;   vb[2] = 4'd15; vq[2] = 8'd0;   vr[2] = 4'd0;
    for (int i = 0; i < 3; i++) begin
      do_op(va[i], vb[i], lat, bcnt, fd);
      total += 2;
      if (bus.quotient !== vq[i]) begin bad++; $display("FAIL vec_quot %0d/%0d got=%0d want=%0d", va[i], vb[i], bus.quotient, vq[i]); end
      if (bus.remainder !== vr[i]) begin bad++; $display("FAIL vec_rem %0d/%0d got=%0d want=%0d", va[i], vb[i], bus.remainder, vr[i]); end
      idle_cycle();
    end
  endtask

  task automatic test_div_zero();
    int lat, bcnt;
    logic fd;
    do_op(8'd100, 4'd0, lat, bcnt, fd);
    total += 5;
    if (bus.quotient !== 8'hFF) begin bad++; $display("FAIL dbz_quot got=%0h want=ff", bus.quotient); end
    if (bus.remainder !== 4'd0) begin bad++; $display("FAIL dbz_rem got=%0d want=0", bus.remainder); end
    if (bus.div_by_zero !== 1'b1) begin bad++; $display("FAIL dbz_flag got=%b want=1", bus.div_by_zero); end
    if (lat != ZERO_LAT) begin bad++; $display("FAIL dbz_latency got=%0d want=%0d", lat, ZERO_LAT); end
    if (bcnt != ZERO_BUSY) begin bad++; $display("FAIL dbz_busy_cycles got=%0d want=%0d", bcnt, ZERO_BUSY); end
    idle_cycle();
    do_op(8'd50, 4'd3, lat, bcnt, fd);
    total++;
    if (bus.div_by_zero !== 1'b0) begin bad++; $display("FAIL dbz_clear got=%b want=0", bus.div_by_zero); end
    idle_cycle();
  endtask

  task automatic test_sweep();
    int lat, bcnt;
    logic fd;
    logic [7:0] eq;
    logic [3:0] er;
    for (int a = 0; a < 256; a++) begin
      for (int b = 1; b < 16; b++) begin
        do_op(8'(a), 4'(b), lat, bcnt, fd);
        eq = 8'(a / b);
        er = 4'(a % b);
        total += 2;
        if (bus.quotient !== eq) begin bad++; $display("FAIL sweep_quot %0d/%0d got=%0d want=%0d", a, b, bus.quotient, eq); end
        if (bus.remainder !== er) begin bad++; $display("FAIL sweep_rem %0d/%0d got=%0d want=%0d", a, b, bus.remainder, er); end
      end
    end
    idle_cycle();
  endtask

  task automatic test_back_to_back();
    int lat, bcnt;
    logic fd, timed_out;
    bus.start    = 1'b1;
    bus.dividend = 8'd200;
    bus.divisor  = 4'd7;
    @(posedge clk); #1;
    bus.start = 1'b0;
    lat = 0;
    timed_out = 1'b1;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk); #1;
      lat++;
      if (lat == 3) begin bus.start = 1'b1; bus.dividend = 8'd50; bus.divisor = 4'd3; end
      if (lat == 4) bus.start = 1'b0;
      if (bus.done) begin timed_out = 1'b0; break; end
    end
    total += 3;
    if (timed_out || lat != 8) begin bad++; $display("FAIL b2b_ignore_latency got=%0d want=8", lat); end
    if (bus.quotient !== 8'd28) begin bad++; $display("FAIL b2b_ignore_quot got=%0d want=28", bus.quotient); end
    if (bus.remainder !== 4'd4) begin bad++; $display("FAIL b2b_ignore_rem got=%0d want=4", bus.remainder); end
    do_op(8'd50, 4'd3, lat, bcnt, fd);
    total += 4;
    if (fd !== 1'b0) begin bad++; $display("FAIL b2b_done_low got=%b want=0", fd); end
    if (lat != 8) begin bad++; $display("FAIL b2b_latency got=%0d want=8", lat); end
    if (bus.quotient !== 8'd16) begin bad++; $display("FAIL b2b_quot got=%0d want=16", bus.quotient); end
    if (bus.remainder !== 4'd2) begin bad++; $display("FAIL b2b_rem got=%0d want=2", bus.remainder); end
    idle_cycle();
  endtask

  task automatic test_reset_mid_run();
    int lat, bcnt;
    logic fd;
    bus.start    = 1'b1;
    bus.dividend = 8'd200;
    bus.divisor  = 4'd7;
    @(posedge clk); #1;
    bus.start = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    total += 5;
    if (bus.busy !== 1'b0) begin bad++; $display("FAIL midrst_busy got=%b want=0", bus.busy); end
    if (bus.done !== 1'b0) begin bad++; $display("FAIL midrst_done got=%b want=0", bus.done); end
    if (bus.div_by_zero !== 1'b0) begin bad++; $display("FAIL midrst_dbz got=%b want=0", bus.div_by_zero); end
    if (bus.quotient !== 8'd0) begin bad++; $display("FAIL midrst_quot got=%0d want=0", bus.quotient); end
    if (bus.remainder !== 4'd0) begin bad++; $display("FAIL midrst_rem got=%0d want=0", bus.remainder); end
    @(posedge clk); #1;
    rst_n = 1'b1;
    repeat (10) begin
      @(posedge clk); #1;
      total++;
      if (bus.busy !== 1'b0 || bus.done !== 1'b0) begin
        bad++;
        $display("FAIL midrst_idle busy=%b done=%b want=0/0", bus.busy, bus.done);
      end
    end
    do_op(8'd9, 4'd2, lat, bcnt, fd);
    total += 3;
    if (lat != 8) begin bad++; $display("FAIL midrst_latency got=%0d want=8", lat); end
    if (bus.quotient !== 8'd4) begin bad++; $display("FAIL midrst_quot2 got=%0d want=4", bus.quotient); end
    if (bus.remainder !== 4'd1) begin bad++; $display("FAIL midrst_rem2 got=%0d want=1", bus.remainder); end
    idle_cycle();
  endtask

  task automatic test_hold();
    int lat, bcnt;
    logic fd;
    do_op(8'd200, 4'd7, lat, bcnt, fd);
    for (int i = 0; i < 20; i++) begin
      bus.dividend = 8'($urandom);
      bus.divisor  = 4'($urandom);
      @(posedge clk); #1;
      total++;
      if (bus.quotient !== 8'd28 || bus.remainder !== 4'd4 || bus.done !== 1'b0) begin
        bad++;
        $display("FAIL hold cycle=%0d got q=%0d r=%0d done=%b want q=28 r=4 done=0",
                 i, bus.quotient, bus.remainder, bus.done);
      end
    end
  endtask

  initial begin
    total = 0;
    bad   = 0;
    test_reset();
    test_basic();
    test_vectors();
    test_div_zero();
    test_back_to_back();
    test_reset_mid_run();
    test_hold();
    test_sweep();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
